// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - default address width (shared with the fetch stage PC)
//   - default word-count width
//   - bytes per instruction word
//   - loader FSM state encoding
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;
    localparam int WORD_BYTES     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Big-endian 8-to-32 assembler. Each accepted byte shifts into the low end of
// the word, so the first byte of a group ends up in [31:24].
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : drop any partial word and return the index to 0
//   load         : a byte is accepted this cycle
//   byte_data    : the byte being accepted
//   word         : assembled word (stable once the 4th byte has been taken)
//   word_full    : strobe, high in the cycle the 4th byte is accepted
// -----------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        word_full = 1'b0;
        if (clear) begin
            word_d = 32'd0;
            idx_d  = 2'd0;
        end else if (load) begin
            word_d    = {word_q[23:0], byte_data};
            idx_d     = idx_q + 2'd1;     // wraps to 0 after the 4th byte
            word_full = (idx_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 32'd0;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Write side of the instruction SRAM. Takes a valid/ready byte stream,
// assembles big-endian 32-bit words and writes them to consecutive
// word-aligned addresses, stalling the pipeline (cpu_hold) while loading.
// Ports:
//   start/base_addr/word_count : begin a load (sampled only in IDLE)
//   abort                      : cancel the load in progress
//   byte_valid/byte_data/byte_ready : input byte stream
//   sram_cs/oe/we/addr/din     : SRAM write port (oe is always 0)
//   busy/cpu_hold              : load in progress / pipeline stall
//   done                       : one-cycle completion pulse
// Optional build macro LOADER_CKSUM_EN adds expected_cksum (in), cksum and
// cksum_err (out): running sum of written words, compared at completion.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
`ifdef LOADER_CKSUM_EN
    ,
    input  logic [31:0]       expected_cksum,
    output logic [31:0]       cksum,
    output logic              cksum_err
`endif
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              zero_done_q, zero_done_d;

    logic        packer_clear;
    logic        byte_accept;
    logic        word_full;
    logic [31:0] word;

    // The low address bits are forced to zero on latch and never used.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^base_addr[1:0];

    assign byte_accept = byte_valid && byte_ready;

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (packer_clear),
        .load      (byte_accept),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        zero_done_d  = 1'b0;
        packer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    packer_clear = 1'b1;
                    if (word_count != '0) begin
                        addr_d   = {base_addr[ADDR_W-1:2], 2'b00};
                        remain_d = word_count;
                        state_d  = ST_COLLECT;
                    end else begin
                        // Empty load: report completion without ever going busy.
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d   = addr_q + ADDR_W'(WORD_BYTES);   // wraps silently
                remain_d = remain_q - CNT_W'(1);
                state_d  = (remain_q == CNT_W'(1)) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything; a write already on the port this cycle
        // still happens because the port is decoded from the current state.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            packer_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        byte_ready = (state_q == ST_COLLECT);
        sram_cs    = (state_q == ST_WRITE);
        sram_we    = (state_q == ST_WRITE);
        sram_oe    = 1'b0;
        sram_addr  = addr_q;
        sram_din   = (state_q == ST_WRITE) ? word : 32'd0;
        busy       = (state_q != ST_IDLE);
        cpu_hold   = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE) || zero_done_q;
    end

`ifdef LOADER_CKSUM_EN
    logic [31:0] cksum_q, cksum_d;
    logic        cksum_err_q, cksum_err_d;

    always_comb begin
        cksum_d     = cksum_q;
        cksum_err_d = cksum_err_q;
        if ((state_q == ST_IDLE) && start) begin
            cksum_d     = 32'd0;
            cksum_err_d = (word_count == '0) ? (expected_cksum != 32'd0) : 1'b0;
        end else if (state_q == ST_WRITE) begin
            cksum_d = cksum_q + word;
            // Settle the verdict on the final write so it is valid with done.
            if (remain_q == CNT_W'(1)) cksum_err_d = (cksum_d != expected_cksum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q     <= 32'd0;
            cksum_err_q <= 1'b0;
        end else begin
            cksum_q     <= cksum_d;
            cksum_err_q <= cksum_err_d;
        end
    end

    assign cksum     = cksum_q;
    assign cksum_err = cksum_err_q;
`endif

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that is the write side of the instruction SRAM read by the fetch stage. It takes a byte stream (valid/ready) from a host or boot source and assembles big-endian 32-bit words. It writes each word to consecutive word-aligned byte addresses through the SRAM port (cs/oe/we/addr/din) and holds the pipeline while loading. It sits between the boot/host interface and the instruction SRAM, muxed with the fetch read port by `cpu_hold`.

Parameters:
- ADDR_W, 32, SRAM byte-address width (PC-compatible).
- CNT_W, 16, width of the word-count field; a load holds at most 2^CNT_W-1 words.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE
- base_addr  input  ADDR_W  first byte address; bits [1:0] are forced to 0 at latch
- word_count  input  CNT_W  number of words to load; latched on start
- abort  input  1  synchronous cancel of the load in progress
- byte_valid  input  1  stream byte present
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- sram_cs  output  1  SRAM chip select
- sram_oe  output  1  SRAM output enable; always 0
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_W  SRAM byte address
- sram_din  output  32  SRAM write data
- busy  output  1  load in progress
- cpu_hold  output  1  stall request to the pipeline; equals busy
- done  output  1  one-cycle pulse when a load completes

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including sram_addr and sram_din.
  - Internal word register, byte index, address and remaining count cleared.
- IDLE:
  - start=1 with word_count≠0: latch {base_addr[ADDR_W-1:2],2'b00} and word_count, then go to COLLECT. busy rises the next cycle.
  - start=1 with word_count=0: done pulses the next cycle and the state stays IDLE.
- COLLECT:
  - byte_ready=1.
  - Each accepted byte (byte_valid && byte_ready) fills the word big-endian: byte 0 into [31:24], byte 1 into [23:16], byte 2 into [15:8], byte 3 into [7:0].
  - On acceptance of byte 3, go to WRITE.
  - Bubbles on byte_valid are allowed and have no timeout.
- WRITE (exactly one cycle):
  - sram_cs=1, sram_we=1, sram_addr=current address, sram_din=assembled word; byte_ready=0.
  - The write occurs in the cycle after byte 3 is accepted.
  - Next: address += 4 (modulo 2^ADDR_W, wraps silently), remaining -= 1.
  - If remaining reaches 0, go to DONE; otherwise go to COLLECT with byte index 0.
- DONE (one cycle): done=1, then go to IDLE. busy and cpu_hold drop when IDLE is entered.
- Outside WRITE: sram_cs=0, sram_we=0, sram_din=0, and sram_addr holds the current address.
- start while busy: ignored.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and the partial word is discarded.
  - A WRITE in the same cycle as abort still completes its single write cycle.
  - done is not pulsed.
  - abort has priority over start.
- Sustained throughput: 5 cycles per word with byte_valid held at 1.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined: adds input `expected_cksum[31:0]`, output `cksum[31:0]`, and output `cksum_err`.
  - cksum is the modulo-2^32 sum of all words written. It clears on an accepted start and is held after done until the next start.
  - cksum_err is valid with done: 1 iff cksum≠expected_cksum. It holds until the next start.
  - cksum_err resets to 0.
- Undefined: these ports and the adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (e.g. `dlx_pkg`):
  - Loader state enum {IDLE, COLLECT, WRITE, DONE}.
  - Constant WORD_BYTES=4.
  - ADDR_W default shared with the fetch stage.
- Sub-module `byte_packer`: 8-to-32 big-endian shift register with a 2-bit index and a `word_full` strobe.
- The FSM, address counter and remaining counter stay in imem_loader.

Test Plan:
- Basic load: base_addr=0x100, word_count=2, bytes 20 01 00 05 00 00 00 2A back-to-back → writes 0x20010005@0x100, then 0x0000002A@0x104; done 1 cycle after the second write; busy low next cycle.
- Alignment and wrap: base_addr=0xFFFFFFFD, word_count=2 → first write @0xFFFFFFFC, second @0x00000000.
- Zero count and ignored start: word_count=0 → done pulse, no sram_we, busy stays 0. A start mid-load → no change to address or count.
- Bubbles and abort:
  - byte_valid toggling every other cycle → same data and addresses as back-to-back.
  - abort after 2 bytes of the word at 0x104 → no write to 0x104, no done, IDLE.
- Async reset mid-WRITE: rst_n=0 while sram_we=1 → all outputs 0 immediately; a fresh load afterward is correct.
- With LOADER_CKSUM_EN: words 0x20010005 and 0x0000002A, expected 0x2001002F → cksum_err=0; expected 0 → cksum_err=1.
